cricket_match_tracker: RTL and testbench
========================================

# cricket_match_tracker

Parametrised two-innings successor to the single-innings cricket tracker. Counts legal balls, overs, runs, extras and wickets per innings, handles wides and no-balls, and latches the first-innings target. It ends the chase automatically and reports the match result. It sits between the ball-event decoder and the scoreboard display logic.

## Interface
- `BALLS_PER_OVER`, 6, legal deliveries per over (2..15).
- `MAX_OVERS`, 20, overs per innings (1..63).
- `MAX_WICKETS`, 10, wickets that end an innings (1..15).
- `RUN_W`, 16, width of run, extras and target counters.
- `EXTRA_PENALTY`, 1, penalty runs added per wide or no-ball.

Ports:
- `clk`  input  1  single clock; all state on the rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `start_match`  input  1  leaves IDLE or MATCH_OVER and starts innings 1.
- `start_innings2`  input  1  leaves BREAK and starts innings 2.
- `ball_bowled`  input  1  one-cycle delivery strobe.
- `ball_type`  input  2  00 legal, 01 wide, 10 no-ball, 11 dead ball.
- `runs_scored`  input  3  runs off the bat or run, 0..7.
- `wicket_fallen`  input  1  wicket on this delivery; sampled only with `ball_bowled`.
- `balls`  output  4  legal balls in the current over.
- `overs`  output  6  completed overs.
- `total_runs`  output  RUN_W  current-innings runs.
- `extras`  output  RUN_W  current-innings extras.
- `wickets`  output  4  current-innings wickets.
- `target`  output  RUN_W  innings-1 runs + 1; 0 until latched.
- `game_state`  output  3  0 IDLE, 1 INNINGS1, 2 BREAK, 3 INNINGS2, 4 MATCH_OVER.
- `innings_active`  output  1  high in INNINGS1 or INNINGS2.
- `result`  output  2  00 none, 01 defending side won, 10 chasing side won, 11 tie.
- `free_hit`  output  1  next delivery is a free hit.

## Operation
- Deliveries count only when `ball_bowled` is high and `innings_active` is high. All other deliveries are ignored.
- Legal ball:
  - runs += `runs_scored`.
  - `balls` increments.
  - At `BALLS_PER_OVER`-1, `balls` wraps to 0 and `overs` increments.
- Wide:
  - runs += `EXTRA_PENALTY` + `runs_scored`.
  - extras += the same amount.
  - `balls` is unchanged.
- No-ball:
  - runs += `EXTRA_PENALTY` + `runs_scored`.
  - extras += `EXTRA_PENALTY` only.
  - `balls` is unchanged.
  - A wicket on a no-ball is ignored.
- Dead ball (11): no counter changes.
- A wicket and runs on the same delivery are both applied. `wickets` never exceeds `MAX_WICKETS`.
- Runs, extras and target saturate at 2^RUN_W-1.
- Innings end is evaluated on the post-update values:
  - `wickets` == `MAX_WICKETS`, or
  - `overs` == `MAX_OVERS`, or
  - (INNINGS2 only) `total_runs` >= `target`.
- INNINGS1 end:
  - Go to BREAK.
  - Latch `target` = `total_runs` + 1.
  - Counters hold their final values.
- BREAK with `start_innings2`:
  - Clear balls, overs, runs, extras and wickets.
  - Go to INNINGS2.
- INNINGS2 end:
  - Go to MATCH_OVER.
  - `result` = 10 if runs >= target.
  - Otherwise 11 if runs == target-1.
  - Otherwise 01.
- MATCH_OVER holds all outputs. `start_match` clears everything, including `target` and `result`, and enters INNINGS1.
- `start_match` is ignored outside IDLE and MATCH_OVER. `start_innings2` is ignored outside BREAK.

## Timing
- Reset asserted: state IDLE and every output 0, immediately and asynchronously. Reset mid-innings discards all counts.
- One-cycle latency from the sampled strobe to the updated outputs.
- The state transition at innings end occurs on the same edge as the final count update. There is no extra cycle.
- A delivery on the same cycle as an innings-ending update cannot occur, because there is one delivery per strobe. The cycle after an innings ends, strobes are ignored.
- Start strobes take effect on the next edge. Counters read 0 in the first active cycle.
- Back-to-back `ball_bowled` on every cycle is supported.

## Configuration
- `FREE_HIT_EN` defined:
  - A counted no-ball sets `free_hit`.
  - `free_hit` persists across wides and dead balls.
  - It clears on the next counted legal ball.
  - While set, `wicket_fallen` is ignored.
  - `free_hit` is cleared at innings start.
- `FREE_HIT_EN` undefined: `free_hit` is tied 0 and wickets on wides and legal balls always count.

## Test plan
- Reset low mid-INNINGS1 with runs=37 -> all outputs 0 and state 0 immediately, with no clock.
- INNINGS1, 120 legal balls at 1 run each (defaults) -> `overs`=20, `balls`=0, state BREAK on the 120th update edge, `target`=121.
- Wide with runs 2, then no-ball with runs 4 -> `total_runs`=8, `extras`=4, `balls` unchanged.
- INNINGS2 with target 50, reaching runs 48 then a legal 3 -> `total_runs`=51, state 4, `result`=10. Further strobes are ignored.
- INNINGS2 with target 50, reaching runs 49 at the 20th over -> `result`=11. With runs 30 and 10 wickets -> `result`=01.
- With `FREE_HIT_EN`: no-ball, wide+wicket, legal+wicket -> `wickets`=0, `free_hit` clears after the legal ball. Without `FREE_HIT_EN`, the same sequence gives `wickets`=2.

Source files
------------

// File: rtl/cricket_match_tracker_if.sv
// Bus between the ball-event decoder (master) and the match tracker (slave).
// Carries the delivery and control strobes in, and the scoreboard values out.
interface cricket_match_tracker_if #(
   parameter int unsigned RUN_W = 16
) ();
   // Decoder -> tracker
   logic             start_match;
   logic             start_innings2;
   logic             ball_bowled;
   logic [1:0]       ball_type;
   logic [2:0]       runs_scored;
   logic             wicket_fallen;
   // Tracker -> scoreboard
   logic [3:0]       balls;
   logic [5:0]       overs;
   logic [RUN_W-1:0] total_runs;
   logic [RUN_W-1:0] extras;
   logic [3:0]       wickets;
   logic [RUN_W-1:0] target;
   logic [2:0]       game_state;
   logic             innings_active;
   logic [1:0]       result;
   logic             free_hit;

   modport master (
      output start_match, start_innings2, ball_bowled, ball_type, runs_scored, wicket_fallen,
      input  balls, overs, total_runs, extras, wickets, target, game_state, innings_active,
             result, free_hit
   );

   modport slave (
      input  start_match, start_innings2, ball_bowled, ball_type, runs_scored, wicket_fallen,
      output balls, overs, total_runs, extras, wickets, target, game_state, innings_active,
             result, free_hit
   );
endinterface

// File: rtl/cricket_match_tracker.sv
// Two-innings cricket match tracker: counts balls, overs, runs, extras and
// wickets per innings, latches the first-innings target, ends the chase
// automatically and reports the result.
// Optional feature macro: FREE_HIT_EN (free hit after a no-ball; wickets
// ignored while the free hit is pending). Default build has free_hit tied 0.
module cricket_match_tracker #(
   parameter int unsigned BALLS_PER_OVER = 6,
   parameter int unsigned MAX_OVERS      = 20,
   parameter int unsigned MAX_WICKETS    = 10,
   parameter int unsigned RUN_W          = 16,
   parameter int unsigned EXTRA_PENALTY  = 1
) (
   input logic                   clk,
   input logic                   reset,
   cricket_match_tracker_if.slave bus
);

   localparam logic [2:0] StIdle  = 3'd0;
   localparam logic [2:0] StInn1  = 3'd1;
   localparam logic [2:0] StBreak = 3'd2;
   localparam logic [2:0] StInn2  = 3'd3;
   localparam logic [2:0] StOver  = 3'd4;

   typedef logic [RUN_W:0] wide_t;

   localparam logic [RUN_W-1:0] RunMax   = '1;
   localparam logic [RUN_W-1:0] RunOne   = {{(RUN_W-1){1'b0}}, 1'b1};
   localparam wide_t            Pen      = wide_t'(EXTRA_PENALTY);
   localparam logic [3:0]       BallLast = 4'(BALLS_PER_OVER - 1);
   localparam logic [5:0]       OverLim  = 6'(MAX_OVERS);
   localparam logic [3:0]       WktLim   = 4'(MAX_WICKETS);

   logic [2:0]       state_q, state_d;
   logic [3:0]       balls_q, balls_d;
   logic [5:0]       overs_q, overs_d;
   logic [RUN_W-1:0] runs_q, runs_d;
   logic [RUN_W-1:0] extras_q, extras_d;
   logic [3:0]       wickets_q, wickets_d;
   logic [RUN_W-1:0] target_q, target_d;
   logic [1:0]       result_q, result_d;
   logic             fh_q;

   logic  innings_active;
   logic  start_m, start_2, counted;
   logic  wkt_take, ended;
   wide_t bat;

   // Saturating add of a (RUN_W+1)-bit increment onto a RUN_W-bit counter
   function automatic logic [RUN_W-1:0] sat_add(input logic [RUN_W-1:0] a, input wide_t b);
      logic [RUN_W+1:0] s;
      s = {2'b00, a} + {1'b0, b};
      return (s > {2'b00, RunMax}) ? RunMax : s[RUN_W-1:0];
   endfunction

   assign innings_active = (state_q == StInn1) || (state_q == StInn2);
   assign start_m = ((state_q == StIdle) || (state_q == StOver)) && bus.start_match;
   assign start_2 = (state_q == StBreak) && bus.start_innings2;
   assign counted = bus.ball_bowled && innings_active;
   assign bat     = wide_t'(bus.runs_scored);

   // Next-state: start strobes, per-delivery counter updates and innings-end handling
   always_comb begin
      state_d   = state_q;
      balls_d   = balls_q;
      overs_d   = overs_q;
      runs_d    = runs_q;
      extras_d  = extras_q;
      wickets_d = wickets_q;
      target_d  = target_q;
      result_d  = result_q;
      wkt_take  = 1'b0;
      ended     = 1'b0;
      if (start_m || start_2) begin
         balls_d   = '0;
         overs_d   = '0;
         runs_d    = '0;
         extras_d  = '0;
         wickets_d = '0;
         if (start_m) begin
            target_d = '0;
            result_d = '0;
            state_d  = StInn1;
         end else begin
            state_d  = StInn2;
         end
      end else if (counted) begin
         unique case (bus.ball_type)
            2'b00: begin
               runs_d = sat_add(runs_q, bat);
               if (balls_q == BallLast) begin
                  balls_d = '0;
                  overs_d = overs_q + 6'd1;
               end else begin
                  balls_d = balls_q + 4'd1;
               end
               wkt_take = !fh_q;
            end
            2'b01: begin
               runs_d   = sat_add(runs_q, Pen + bat);
               extras_d = sat_add(extras_q, Pen + bat);
               wkt_take = !fh_q;
            end
            2'b10: begin
               // Wicket on a no-ball never counts
               runs_d   = sat_add(runs_q, Pen + bat);
               extras_d = sat_add(extras_q, Pen);
            end
            default: ;
         endcase
         if (wkt_take && bus.wicket_fallen && (wickets_q < WktLim)) begin
            wickets_d = wickets_q + 4'd1;
         end
         // End test uses post-update values so the transition shares the final count edge
         ended = (wickets_d == WktLim) || (overs_d == OverLim) ||
                 ((state_q == StInn2) && (runs_d >= target_q));
         if (ended && (state_q == StInn1)) begin
            state_d  = StBreak;
            target_d = sat_add(runs_d, wide_t'(1));
         end else if (ended) begin
            state_d = StOver;
            if (runs_d >= target_q) begin
               result_d = 2'b10;
            end else if (runs_d == (target_q - RunOne)) begin
               result_d = 2'b11;
            end else begin
               result_d = 2'b01;
            end
         end
      end
   end

   // State and counter registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q   <= StIdle;
         balls_q   <= '0;
         overs_q   <= '0;
         runs_q    <= '0;
         extras_q  <= '0;
         wickets_q <= '0;
         target_q  <= '0;
         result_q  <= '0;
      end else begin
         state_q   <= state_d;
         balls_q   <= balls_d;
         overs_q   <= overs_d;
         runs_q    <= runs_d;
         extras_q  <= extras_d;
         wickets_q <= wickets_d;
         target_q  <= target_d;
         result_q  <= result_d;
      end
   end

`ifdef FREE_HIT_EN
   logic fh_d;

   // Free hit: set by a counted no-ball, kept over wides/dead balls, cleared by a legal ball
   always_comb begin
      fh_d = fh_q;
      if (start_m || start_2) begin
         fh_d = 1'b0;
      end else if (counted) begin
         if (bus.ball_type == 2'b00) begin
            fh_d = 1'b0;
         end else if (bus.ball_type == 2'b10) begin
            fh_d = 1'b1;
         end
      end
   end

   // Free-hit flag register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         fh_q <= 1'b0;
      end else begin
         fh_q <= fh_d;
      end
   end
`else
   assign fh_q = 1'b0;
`endif

   assign bus.balls          = balls_q;
   assign bus.overs          = overs_q;
   assign bus.total_runs     = runs_q;
   assign bus.extras         = extras_q;
   assign bus.wickets        = wickets_q;
   assign bus.target         = target_q;
   assign bus.game_state     = state_q;
   assign bus.innings_active = innings_active;
   assign bus.result         = result_q;
   assign bus.free_hit       = fh_q;

endmodule

// File: tb/tb_cricket_match_tracker.sv
// Directed, table-driven bench for cricket_match_tracker with default parameters.
// Inputs change on the falling edge; outputs are checked on the next falling edge.
module tb_cricket_match_tracker;

`ifdef FREE_HIT_EN
   localparam int FH = 1;
`else
   localparam int FH = 0;
`endif

   logic clk;
   logic reset;
   int   n_total;
   int   n_bad;

   cricket_match_tracker_if #(.RUN_W(16)) bus ();

   cricket_match_tracker dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [1:0] bt;
      logic [2:0] rs;
      logic       wk;
      int         e_balls;
      int         e_overs;
      int         e_runs;
      int         e_extras;
      int         e_wkts;
      int         e_state;
   } vec_t;

   vec_t vecs[14];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   task automatic bowl(input logic [1:0] t, input logic [2:0] r, input logic w);
      bus.ball_type     = t;
      bus.runs_scored   = r;
      bus.wicket_fallen = w;
      bus.ball_bowled   = 1'b1;
      @(negedge clk);
      bus.ball_bowled   = 1'b0;
      bus.wicket_fallen = 1'b0;
   endtask

   task automatic bowl_n(input int n, input logic [2:0] r, input logic w);
      for (int i = 0; i < n; i++) bowl(2'b00, r, w);
   endtask

   task automatic pulse_start_match();
      bus.start_match = 1'b1;
      @(negedge clk);
      bus.start_match = 1'b0;
   endtask

   task automatic pulse_innings2();
      bus.start_innings2 = 1'b1;
      @(negedge clk);
      bus.start_innings2 = 1'b0;
   endtask

   // Innings 1 finishing on 49 all out, so the target becomes 50, then start innings 2
   task automatic setup_chase_50();
      pulse_start_match();
      chk("new_match_target", bus.target, 0);
      chk("new_match_result", bus.result, 0);
      bowl_n(7, 3'd7, 1'b0);
      bowl_n(10, 3'd0, 1'b1);
      chk("inn1_allout_state", bus.game_state, 2);
      chk("inn1_allout_target", bus.target, 50);
      pulse_innings2();
      chk("inn2_start_state", bus.game_state, 3);
      chk("inn2_start_runs", bus.total_runs, 0);
      chk("inn2_start_wkts", bus.wickets, 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1);
   end

   initial begin
      n_total = 0;
      n_bad   = 0;
      //               bt     rs    wk  balls overs runs extras wkts state
      vecs[0]  = '{2'b01, 3'd2, 1'b0, 0, 0,  3, 3, 0, 1};  // wide 2
      vecs[1]  = '{2'b10, 3'd4, 1'b0, 0, 0,  8, 4, 0, 1};  // no-ball 4
      vecs[2]  = '{2'b11, 3'd6, 1'b1, 0, 0,  8, 4, 0, 1};  // dead ball
      vecs[3]  = '{2'b00, 3'd0, 1'b0, 1, 0,  8, 4, 0, 1};
      vecs[4]  = '{2'b00, 3'd6, 1'b1, 2, 0, 14, 4, 1, 1};  // runs + wicket together
      vecs[5]  = '{2'b10, 3'd0, 1'b1, 2, 0, 15, 5, 1, 1};  // wicket on no-ball ignored
      vecs[6]  = '{2'b00, 3'd1, 1'b0, 3, 0, 16, 5, 1, 1};
      vecs[7]  = '{2'b01, 3'd0, 1'b1, 3, 0, 17, 6, 2, 1};  // wicket on wide counts
      vecs[8]  = '{2'b00, 3'd2, 1'b0, 4, 0, 19, 6, 2, 1};
      vecs[9]  = '{2'b00, 3'd3, 1'b0, 5, 0, 22, 6, 2, 1};
      vecs[10] = '{2'b00, 3'd0, 1'b0, 0, 1, 22, 6, 2, 1};  // over wraps
      vecs[11] = '{2'b00, 3'd7, 1'b0, 1, 1, 29, 6, 2, 1};
      vecs[12] = '{2'b00, 3'd4, 1'b0, 2, 1, 33, 6, 2, 1};
      vecs[13] = '{2'b00, 3'd4, 1'b0, 3, 1, 37, 6, 2, 1};

      reset              = 1'b0;
      bus.start_match    = 1'b0;
      bus.start_innings2 = 1'b0;
      bus.ball_bowled    = 1'b0;
      bus.ball_type      = 2'b00;
      bus.runs_scored    = 3'd0;
      bus.wicket_fallen  = 1'b0;
      #1;
      chk("reset_state", bus.game_state, 0);
      chk("reset_active", bus.innings_active, 0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("idle_state", bus.game_state, 0);

      // Deliveries in IDLE are ignored
      bowl(2'b00, 3'd4, 1'b0);
      chk("idle_ball_ignored", bus.total_runs, 0);

      pulse_start_match();
      chk("inn1_state", bus.game_state, 1);
      chk("inn1_active", bus.innings_active, 1);
      chk("inn1_runs0", bus.total_runs, 0);
      pulse_innings2();
      chk("inn2_strobe_ignored", bus.game_state, 1);

      for (int i = 0; i < 14; i++) begin
         bowl(vecs[i].bt, vecs[i].rs, vecs[i].wk);
         chk($sformatf("v%0d_balls", i), bus.balls, vecs[i].e_balls);
         chk($sformatf("v%0d_overs", i), bus.overs, vecs[i].e_overs);
         chk($sformatf("v%0d_runs", i), bus.total_runs, vecs[i].e_runs);
         chk($sformatf("v%0d_extras", i), bus.extras, vecs[i].e_extras);
         chk($sformatf("v%0d_wkts", i), bus.wickets, vecs[i].e_wkts);
         chk($sformatf("v%0d_state", i), bus.game_state, vecs[i].e_state);
      end

      pulse_start_match();
      chk("start_match_ignored_runs", bus.total_runs, 37);
      chk("start_match_ignored_state", bus.game_state, 1);

      // Asynchronous reset mid-innings, away from any rising edge
      #2;
      reset = 1'b0;
      #1;
      chk("async_rst_state", bus.game_state, 0);
      chk("async_rst_runs", bus.total_runs, 0);
      chk("async_rst_extras", bus.extras, 0);
      chk("async_rst_balls", bus.balls, 0);
      chk("async_rst_overs", bus.overs, 0);
      chk("async_rst_wkts", bus.wickets, 0);
      chk("async_rst_target", bus.target, 0);
      chk("async_rst_result", bus.result, 0);
      chk("async_rst_active", bus.innings_active, 0);
      chk("async_rst_fh", bus.free_hit, 0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      // Full 20-over innings, back-to-back deliveries
      pulse_start_match();
      bus.ball_type     = 2'b00;
      bus.runs_scored   = 3'd1;
      bus.wicket_fallen = 1'b0;
      bus.ball_bowled   = 1'b1;
      for (int i = 1; i <= 120; i++) begin
         @(negedge clk);
         if (i == 119) begin
            chk("b119_state", bus.game_state, 1);
            chk("b119_balls", bus.balls, 5);
            chk("b119_overs", bus.overs, 19);
         end
      end
      chk("b120_state", bus.game_state, 2);
      chk("b120_overs", bus.overs, 20);
      chk("b120_balls", bus.balls, 0);
      chk("b120_runs", bus.total_runs, 120);
      chk("b120_target", bus.target, 121);
      chk("b120_active", bus.innings_active, 0);
      @(negedge clk);
      bus.ball_bowled = 1'b0;
      chk("break_ball_ignored", bus.total_runs, 120);
      pulse_start_match();
      chk("break_start_match_ignored", bus.game_state, 2);
      pulse_innings2();
      chk("inn2_after_120_state", bus.game_state, 3);
      chk("inn2_after_120_overs", bus.overs, 0);
      chk("inn2_after_120_target", bus.target, 121);

      // Reset again, then chase of 50 won by reaching 51
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      setup_chase_50();
      bowl_n(6, 3'd7, 1'b0);
      bowl(2'b00, 3'd6, 1'b0);
      chk("chase_48_runs", bus.total_runs, 48);
      chk("chase_48_state", bus.game_state, 3);
      bowl(2'b00, 3'd3, 1'b0);
      chk("chase_win_runs", bus.total_runs, 51);
      chk("chase_win_state", bus.game_state, 4);
      chk("chase_win_result", bus.result, 2);
      chk("chase_win_active", bus.innings_active, 0);
      bowl(2'b00, 3'd7, 1'b0);
      chk("over_ball_ignored", bus.total_runs, 51);
      pulse_innings2();
      chk("over_inn2_ignored", bus.game_state, 4);

      // Tie: 49 after 20 overs
      setup_chase_50();
      bowl_n(49, 3'd1, 1'b0);
      bowl_n(71, 3'd0, 1'b0);
      chk("tie_runs", bus.total_runs, 49);
      chk("tie_overs", bus.overs, 20);
      chk("tie_state", bus.game_state, 4);
      chk("tie_result", bus.result, 3);

      // Defended: 30 all out
      setup_chase_50();
      bowl_n(5, 3'd6, 1'b0);
      bowl_n(10, 3'd0, 1'b1);
      chk("defend_runs", bus.total_runs, 30);
      chk("defend_wkts", bus.wickets, 10);
      chk("defend_state", bus.game_state, 4);
      chk("defend_result", bus.result, 1);

      // Free-hit sequence: no-ball, wide + wicket, legal + wicket
      pulse_start_match();
      chk("fh_start_result", bus.result, 0);
      chk("fh_start_target", bus.target, 0);
      bowl(2'b10, 3'd0, 1'b0);
      chk("fh_nb_flag", bus.free_hit, FH);
      chk("fh_nb_runs", bus.total_runs, 1);
      bowl(2'b01, 3'd0, 1'b1);
      chk("fh_wide_flag", bus.free_hit, FH);
      chk("fh_wide_wkts", bus.wickets, (FH != 0) ? 0 : 1);
      bowl(2'b00, 3'd0, 1'b1);
      chk("fh_legal_flag", bus.free_hit, 0);
      chk("fh_legal_wkts", bus.wickets, (FH != 0) ? 0 : 2);
      chk("fh_legal_balls", bus.balls, 1);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
